// File: rtl/param_fifo.sv
// Synchronous FIFO with registered read data and fill-level status flags.
// Define FIFO_ERR_FLAGS_EN to build the sticky overflow/underflow flags; otherwise both are tied to 0.
module param_fifo #(
    parameter int BIT_DEPTH       = 8,
    parameter int FIFO_VOLUME     = 16,
    parameter int ALMOST_FULL_LVL = 12
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enable_write,
    input  logic [BIT_DEPTH-1:0]         value_to_write,
    input  logic                         enable_read,
    output logic [BIT_DEPTH-1:0]         value_to_read,
    output logic                         full,
    output logic                         empty,
    output logic                         almost_full,
    output logic [$clog2(FIFO_VOLUME):0] fill_count,
    output logic                         overflow,
    output logic                         underflow
);

    localparam int AW = $clog2(FIFO_VOLUME);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_LVL = CW'(FIFO_VOLUME);
    localparam logic [CW-1:0] AF_LVL   = CW'(ALMOST_FULL_LVL);

    logic [BIT_DEPTH-1:0] mem_q [FIFO_VOLUME];
    logic [AW-1:0]        head_q, head_d;
    logic [AW-1:0]        tail_q, tail_d;
    logic [CW-1:0]        count_q, count_d;
    logic [BIT_DEPTH-1:0] rd_data_q, rd_data_d;
    logic                 rd_accept, wr_accept;

    assign full        = (count_q == FULL_LVL);
    assign empty       = (count_q == '0);
    assign almost_full = (count_q >= AF_LVL);
    assign fill_count  = count_q;
    assign value_to_read = rd_data_q;

    // A full FIFO still takes a write when a read frees the head slot on the same edge.
    assign rd_accept = enable_read && !empty;
    assign wr_accept = enable_write && (!full || enable_read);

    always_comb begin
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        rd_data_d = rd_data_q;
        if (rd_accept) begin
            head_d    = head_q + AW'(1);
            rd_data_d = mem_q[head_q];
        end
        if (wr_accept) begin
            tail_d = tail_q + AW'(1);
        end
        case ({wr_accept, rd_accept})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            rd_data_q <= '0;
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            rd_data_q <= rd_data_d;
        end
    end

    // Storage is not reset; pointers and count define which entries are valid.
    always_ff @(posedge clk) begin
        if (!rst && wr_accept) begin
            mem_q[tail_q] <= value_to_write;
        end
    end

`ifdef FIFO_ERR_FLAGS_EN
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;

    always_comb begin
        overflow_d  = overflow_q  | (enable_write && full && !enable_read);
        underflow_d = underflow_q | (enable_read && empty);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`else
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_param_fifo.sv
// Directed self-checking bench for param_fifo at default parameters.
// Flag expectations follow whether FIFO_ERR_FLAGS_EN is defined for the build.
module tb_param_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable_write;
    logic [7:0] value_to_write;
    logic       enable_read;
    logic [7:0] value_to_read;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic [4:0] fill_count;
    logic       overflow;
    logic       underflow;

    int errors = 0;
    int checks = 0;

`ifdef FIFO_ERR_FLAGS_EN
    localparam logic FLAG_EXP = 1'b1;
`else
    localparam logic FLAG_EXP = 1'b0;
`endif

    param_fifo dut (
        .clk           (clk),
        .rst           (rst),
        .enable_write  (enable_write),
        .value_to_write(value_to_write),
        .enable_read   (enable_read),
        .value_to_read (value_to_read),
        .full          (full),
        .empty         (empty),
        .almost_full   (almost_full),
        .fill_count    (fill_count),
        .overflow      (overflow),
        .underflow     (underflow)
    );

    always #5 clk = ~clk;

    // Drive on the falling edge, let one rising edge pass, then settle before checks.
    task automatic applyStimulus(input logic r, input logic we, input logic [7:0] wd, input logic re);
        @(negedge clk);
        rst            = r;
        enable_write   = we;
        value_to_write = wd;
        enable_read    = re;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    initial begin
        rst = 1'b1; enable_write = 1'b0; value_to_write = '0; enable_read = 1'b0;

        // Reset state
        applyStimulus(1'b1, 1'b0, 8'd0, 1'b0);
        applyStimulus(1'b1, 1'b0, 8'd0, 1'b0);
        checkOutput("rst_fill", 32'(fill_count), 32'd0);
        checkOutput("rst_empty", 32'(empty), 32'd1);
        checkOutput("rst_full", 32'(full), 32'd0);
        checkOutput("rst_af", 32'(almost_full), 32'd0);
        checkOutput("rst_vtr", 32'(value_to_read), 32'd0);
        checkOutput("rst_ovf", 32'(overflow), 32'd0);
        checkOutput("rst_unf", 32'(underflow), 32'd0);

        // Single write then read
        applyStimulus(1'b0, 1'b1, 8'd7, 1'b0);
        checkOutput("w7_fill", 32'(fill_count), 32'd1);
        checkOutput("w7_empty", 32'(empty), 32'd0);
        applyStimulus(1'b0, 1'b0, 8'd0, 1'b1);
        checkOutput("r7_vtr", 32'(value_to_read), 32'd7);
        checkOutput("r7_empty", 32'(empty), 32'd1);
        checkOutput("r7_fill", 32'(fill_count), 32'd0);
        applyStimulus(1'b0, 1'b0, 8'd0, 1'b0);
        checkOutput("hold_vtr", 32'(value_to_read), 32'd7);

        // Fill to capacity, check almost_full/full thresholds, overflow on a 17th write
        for (int k = 1; k <= 16; k++) begin
            applyStimulus(1'b0, 1'b1, 8'(k), 1'b0);
            checkOutput($sformatf("fill_cnt%0d", k), 32'(fill_count), 32'(k));
            checkOutput($sformatf("fill_af%0d", k), 32'(almost_full), (k >= 12) ? 32'd1 : 32'd0);
            checkOutput($sformatf("fill_full%0d", k), 32'(full), (k == 16) ? 32'd1 : 32'd0);
        end
        applyStimulus(1'b0, 1'b1, 8'd99, 1'b0);
        checkOutput("ovf_fill", 32'(fill_count), 32'd16);
        checkOutput("ovf_full", 32'(full), 32'd1);
        checkOutput("ovf_flag", 32'(overflow), 32'(FLAG_EXP));
        for (int k = 1; k <= 16; k++) begin
            applyStimulus(1'b0, 1'b0, 8'd0, 1'b1);
            checkOutput($sformatf("drain_vtr%0d", k), 32'(value_to_read), 32'(k));
            checkOutput($sformatf("drain_cnt%0d", k), 32'(fill_count), 32'(16 - k));
        end
        checkOutput("drain_empty", 32'(empty), 32'd1);

        // Simultaneous read/write on a full FIFO
        applyStimulus(1'b1, 1'b0, 8'd0, 1'b0);
        checkOutput("rst2_ovf", 32'(overflow), 32'd0);
        for (int k = 0; k < 16; k++) applyStimulus(1'b0, 1'b1, 8'(30 + k), 1'b0);
        applyStimulus(1'b0, 1'b1, 8'd88, 1'b1);
        checkOutput("fullrw_vtr", 32'(value_to_read), 32'd30);
        checkOutput("fullrw_full", 32'(full), 32'd1);
        checkOutput("fullrw_ovf", 32'(overflow), 32'd0);

        // Steady 8-deep streaming with pointer wrap
        applyStimulus(1'b1, 1'b0, 8'd0, 1'b0);
        for (int k = 0; k < 8; k++) applyStimulus(1'b0, 1'b1, 8'(50 + k), 1'b0);
        checkOutput("hold8_fill", 32'(fill_count), 32'd8);
        for (int k = 0; k < 20; k++) begin
            applyStimulus(1'b0, 1'b1, 8'(100 + k), 1'b1);
            checkOutput($sformatf("rw_vtr%0d", k), 32'(value_to_read), (k < 8) ? 32'(50 + k) : 32'(100 + k - 8));
            checkOutput($sformatf("rw_cnt%0d", k), 32'(fill_count), 32'd8);
        end
        for (int k = 0; k < 8; k++) begin
            applyStimulus(1'b0, 1'b0, 8'd0, 1'b1);
            checkOutput($sformatf("rwdrain_vtr%0d", k), 32'(value_to_read), 32'(112 + k));
        end
        checkOutput("rwdrain_empty", 32'(empty), 32'd1);

        // Simultaneous read/write on an empty FIFO: only the write lands
        applyStimulus(1'b0, 1'b1, 8'd12, 1'b1);
        checkOutput("erw_fill", 32'(fill_count), 32'd1);
        checkOutput("erw_vtr", 32'(value_to_read), 32'd119);
        checkOutput("erw_unf", 32'(underflow), 32'(FLAG_EXP));
        applyStimulus(1'b0, 1'b0, 8'd0, 1'b1);
        checkOutput("erw_next", 32'(value_to_read), 32'd12);
        applyStimulus(1'b0, 1'b0, 8'd0, 1'b1);
        checkOutput("eread_vtr", 32'(value_to_read), 32'd12);
        checkOutput("eread_fill", 32'(fill_count), 32'd0);

        // Reset with a concurrent write mid-operation
        for (int k = 0; k < 5; k++) applyStimulus(1'b0, 1'b1, 8'(60 + k), 1'b0);
        checkOutput("hold5_fill", 32'(fill_count), 32'd5);
        applyStimulus(1'b1, 1'b1, 8'd77, 1'b0);
        checkOutput("rstw_fill", 32'(fill_count), 32'd0);
        checkOutput("rstw_empty", 32'(empty), 32'd1);
        checkOutput("rstw_vtr", 32'(value_to_read), 32'd0);
        checkOutput("rstw_ovf", 32'(overflow), 32'd0);
        checkOutput("rstw_unf", 32'(underflow), 32'd0);
        applyStimulus(1'b0, 1'b0, 8'd0, 1'b1);
        checkOutput("rstw_rd_vtr", 32'(value_to_read), 32'd0);
        checkOutput("rstw_rd_fill", 32'(fill_count), 32'd0);
        checkOutput("rstw_rd_unf", 32'(underflow), 32'(FLAG_EXP));
        applyStimulus(1'b0, 1'b1, 8'd3, 1'b0);
        applyStimulus(1'b0, 1'b0, 8'd0, 1'b1);
        checkOutput("post_rst_vtr", 32'(value_to_read), 32'd3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/param_fifo.md
PARAM_FIFO -- requirements
Module: param_fifo

Interface
REQ-001 The block SHALL have parameter BIT_DEPTH, default 8, giving the data word width in bits.
REQ-002 The block SHALL have parameter FIFO_VOLUME, default 16, giving the number of storage entries (power of two, at least 4).
REQ-003 The block SHALL have parameter ALMOST_FULL_LVL, default 12, giving the fill level at which almost_full asserts (1 to FIFO_VOLUME-1).
REQ-004 The block SHALL have one clock and a synchronous, active-high reset, with ports named clk and rst.
REQ-005 The port list SHALL be, in order:
  - clk  input  1  clock; all state changes on the rising edge
  - rst  input  1  synchronous active-high reset
  - enable_write  input  1  write request
  - value_to_write  input  BIT_DEPTH  write data
  - enable_read  input  1  read request
  - value_to_read  output  BIT_DEPTH  registered read data
  - full  output  1  FIFO holds FIFO_VOLUME words
  - empty  output  1  FIFO holds 0 words
  - almost_full  output  1  fill_count >= ALMOST_FULL_LVL
  - fill_count  output  clog2(FIFO_VOLUME)+1  number of stored words
  - overflow  output  1  sticky error flag (macro-dependent, see REQ-020)
  - underflow  output  1  sticky error flag (macro-dependent, see REQ-020)

Function
REQ-006 The block SHALL accept a write on a rising edge when enable_write=1 and full=0, storing value_to_write at the tail pointer and advancing the tail pointer by 1.
REQ-007 The block SHALL accept a read on a rising edge when enable_read=1 and empty=0, loading the word at the head pointer into value_to_read on that edge (1-cycle latency) and advancing the head pointer by 1.
REQ-008 value_to_read SHALL hold its last value in every cycle without an accepted read.
REQ-009 The head and tail pointers SHALL wrap from FIFO_VOLUME-1 to 0.
REQ-010 fill_count SHALL increase by 1 on a write-only accept, decrease by 1 on a read-only accept, and stay unchanged on a simultaneous accept or when nothing is accepted.
REQ-011 full, empty and almost_full SHALL be decoded combinationally from the registered fill_count, with no extra latency.
REQ-012 With simultaneous requests and empty=1, only the write SHALL be accepted; value_to_read is unchanged.
REQ-013 With simultaneous requests and full=1, both the read and the write SHALL be accepted, and full stays 1.
REQ-014 With simultaneous requests at any other level, both SHALL be accepted, and the read SHALL return the oldest word, never the word being written.
REQ-015 A write request while full=1 (without a read) SHALL be dropped, with storage and pointers unchanged.
REQ-016 A read request while empty=1 SHALL be ignored, with value_to_read and pointers unchanged.

Reset
REQ-017 On a rising edge with rst=1 the block SHALL set both pointers, fill_count and value_to_read to 0, set empty=1, full=0 and almost_full=0, and clear overflow and underflow.
REQ-018 rst SHALL take priority over simultaneous read and write requests, which are discarded; a reset mid-operation discards all stored words.
REQ-019 Storage array contents SHALL NOT need to be cleared by reset.

Configuration
REQ-020 With macro FIFO_ERR_FLAGS_EN defined:
  - overflow SHALL set to 1 on the edge where a write is dropped per REQ-015.
  - underflow SHALL set to 1 on the edge where a read is ignored per REQ-016 or REQ-012.
  - Both flags SHALL stay set until rst.
REQ-021 Without FIFO_ERR_FLAGS_EN, overflow and underflow SHALL be tied to 0 and no flag logic SHALL be synthesised.

Verification (defaults: BIT_DEPTH=8, FIFO_VOLUME=16, ALMOST_FULL_LVL=12)
REQ-022 Reset then write 7 then read: after the write, fill_count=1 and empty=0; value_to_read=7 one edge after the read request; then empty=1 and fill_count=0.
REQ-023 Write 1..16 back-to-back: almost_full rises after the 12th write; full=1 after the 16th; a 17th write of 99 is dropped and overflow=1 (macro on); reading 16 words returns 1..16 in order.
REQ-024 Hold 8 words, then issue simultaneous read and write for 20 cycles with writes 100..119: fill_count stays 8; reads return the original 8 words, then 100..111; the pointers wrap without corruption.
REQ-025 Empty FIFO with simultaneous read and write of 12: fill_count=1; value_to_read is unchanged; underflow=1 (macro on) or 0 (macro off); the next read returns 12.
REQ-026 Hold 5 words, then assert rst together with enable_write=1: fill_count=0, empty=1, value_to_read=0, flags cleared, and the write is not stored.
